// File: rtl/mem_bus_arbiter_if.sv
// Shared memory bus between the arbiter (master) and the memory/fabric (slave).
interface mem_bus_arbiter_if;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_rdata_i;
    logic        bus_ack_i;

    modport master (
        output bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_sel_o,
        input  bus_rdata_i, bus_ack_i
    );

    modport slave (
        input  bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_sel_o,
        output bus_rdata_i, bus_ack_i
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-client (instruction fetch / MEM stage) arbiter onto a single shared bus.
// MEM has priority unless IF has been passed over STARVE_MAX times in a row.
// Each granted access has a bus-ack timeout that completes it with an error.
module mem_bus_arbiter #(
    parameter int TIMEOUT    = 16,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    // instruction fetch client
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_rdata_o,
    output logic        if_ack_o,
    output logic        if_err_o,
    // MEM stage client
    input  logic        mem_req_i,
    input  logic        mem_we_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    input  logic [3:0]  mem_sel_i,
    output logic [31:0] mem_rdata_o,
    output logic        mem_ack_o,
    output logic        mem_err_o,
    // stage controller
    output logic        stall_if_o,
    output logic        stall_mem_o,
    // shared bus
    mem_bus_arbiter_if.master bus
);

    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int SRV_W = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_MEM} state_t;

    state_t      state, state_nxt;
    logic [TMO_W-1:0] tmo_cnt, tmo_nxt;
    logic [SRV_W-1:0] starve_cnt, starve_nxt;

    logic        req_q, req_nxt;
    logic        we_q, we_nxt;
    logic [31:0] addr_q, addr_nxt;
    logic [31:0] wdata_q, wdata_nxt;
    logic [3:0]  sel_q, sel_nxt;

    logic busy, ack_ok, expire, done, if_wins;

    assign bus.bus_req_o   = req_q;
    assign bus.bus_we_o    = we_q;
    assign bus.bus_addr_o  = addr_q;
    assign bus.bus_wdata_o = wdata_q;
    assign bus.bus_sel_o   = sel_q;

    // Completion qualifiers: ack only counts while our strobe is up, so a late
    // ack after reset or after a timeout is dropped; a real ack beats expiry.
    assign busy    = (state != IDLE);
    assign ack_ok  = req_q & bus.bus_ack_i;
    assign expire  = busy & ~ack_ok & (tmo_cnt == TMO_W'(TIMEOUT - 1));
    assign done    = busy & (ack_ok | expire);
    assign if_wins = if_req_i & (~mem_req_i | (starve_cnt == SRV_W'(STARVE_MAX)));

    // State, counters and registered bus drive.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            tmo_cnt    <= '0;
            starve_cnt <= '0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            sel_q      <= '0;
        end else begin
            state      <= state_nxt;
            tmo_cnt    <= tmo_nxt;
            starve_cnt <= starve_nxt;
            req_q      <= req_nxt;
            we_q       <= we_nxt;
            addr_q     <= addr_nxt;
            wdata_q    <= wdata_nxt;
            sel_q      <= sel_nxt;
        end
    end

    // Next-state: grant selection in IDLE, completion/timeout tracking in BUSY.
    always_comb begin
        state_nxt  = state;
        tmo_nxt    = tmo_cnt;
        starve_nxt = starve_cnt;
        req_nxt    = req_q;
        we_nxt     = we_q;
        addr_nxt   = addr_q;
        wdata_nxt  = wdata_q;
        sel_nxt    = sel_q;
        case (state)
            IDLE: begin
                if (!if_req_i)
                    starve_nxt = '0;
                if (if_wins) begin
                    state_nxt  = BUSY_IF;
                    req_nxt    = 1'b1;
                    we_nxt     = 1'b0;
                    addr_nxt   = if_addr_i;
                    wdata_nxt  = '0;
                    sel_nxt    = 4'hF;
                    tmo_nxt    = '0;
                    starve_nxt = '0;
                end else if (mem_req_i) begin
                    state_nxt  = BUSY_MEM;
                    req_nxt    = 1'b1;
                    we_nxt     = mem_we_i;
                    addr_nxt   = mem_addr_i;
                    wdata_nxt  = mem_wdata_i;
                    sel_nxt    = mem_sel_i;
                    tmo_nxt    = '0;
                    if (if_req_i && starve_cnt != SRV_W'(STARVE_MAX))
                        starve_nxt = starve_cnt + 1'b1;
                end
            end
            BUSY_IF, BUSY_MEM: begin
                if (done) begin
                    state_nxt = IDLE;
                    req_nxt   = 1'b0;
                end else begin
                    tmo_nxt = tmo_cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Client responses: owner-only, combinational with the bus ack, silent in reset.
    always_comb begin
        if_ack_o    = ~rst & (state == BUSY_IF)  & done;
        mem_ack_o   = ~rst & (state == BUSY_MEM) & done;
        if_err_o    = if_ack_o  & ~ack_ok;
        mem_err_o   = mem_ack_o & ~ack_ok;
        if_rdata_o  = (if_ack_o  & ack_ok) ? bus.bus_rdata_i : 32'h0;
        mem_rdata_o = (mem_ack_o & ack_ok) ? bus.bus_rdata_i : 32'h0;
        stall_if_o  = ~rst & if_req_i  & ~if_ack_o;
        stall_mem_o = ~rst & mem_req_i & ~mem_ack_o;
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: load, simultaneous requests, wait-state
// stall, starvation hand-over, timeout, ack-at-expiry and reset abandonment.
module tb_mem_bus_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_rdata_o;
    logic        if_ack_o, if_err_o;
    logic        mem_req_i, mem_we_i;
    logic [31:0] mem_addr_i, mem_wdata_i;
    logic [3:0]  mem_sel_i;
    logic [31:0] mem_rdata_o;
    logic        mem_ack_o, mem_err_o;
    logic        stall_if_o, stall_mem_o;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc;

    mem_bus_arbiter_if bus ();

    mem_bus_arbiter #(.TIMEOUT(16), .STARVE_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o),
        .if_ack_o(if_ack_o), .if_err_o(if_err_o),
        .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i),
        .mem_wdata_i(mem_wdata_i), .mem_sel_i(mem_sel_i), .mem_rdata_o(mem_rdata_o),
        .mem_ack_o(mem_ack_o), .mem_err_o(mem_err_o),
        .stall_if_o(stall_if_o), .stall_mem_o(stall_mem_o),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset with a pending request and a stray ack: everything quiet
        rst = 1'b1;
        if_req_i = 1'b0; if_addr_i = '0;
        mem_req_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h0; mem_wdata_i = '0; mem_sel_i = 4'hF;
        bus.bus_ack_i = 1'b1; bus.bus_rdata_i = 32'h5555_AAAA;
        tick(); tick();
        @(negedge clk);
        chk("rst_bus_req",   {31'b0, bus.bus_req_o}, 32'h0);
        chk("rst_bus_sel",   {28'b0, bus.bus_sel_o}, 32'h0);
        chk("rst_bus_addr",  bus.bus_addr_o, 32'h0);
        chk("rst_mem_ack",   {31'b0, mem_ack_o}, 32'h0);
        chk("rst_mem_rdata", mem_rdata_o, 32'h0);
        chk("rst_stall_mem", {31'b0, stall_mem_o}, 32'h0);
        tick();
        rst = 1'b0; mem_req_i = 1'b0; bus.bus_ack_i = 1'b0;

        // single load, bus acks one cycle after strobe
        tick();
        mem_req_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h100; mem_sel_i = 4'hF;
        @(negedge clk);
        chk("ld_idle_req",   {31'b0, bus.bus_req_o}, 32'h0);
        chk("ld_idle_stall", {31'b0, stall_mem_o}, 32'h1);
        tick();
        @(negedge clk);
        chk("ld_bus_req",  {31'b0, bus.bus_req_o}, 32'h1);
        chk("ld_bus_addr", bus.bus_addr_o, 32'h100);
        chk("ld_wait_ack", {31'b0, mem_ack_o}, 32'h0);
        tick();
        bus.bus_ack_i = 1'b1; bus.bus_rdata_i = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("ld_ack",    {31'b0, mem_ack_o}, 32'h1);
        chk("ld_rdata",  mem_rdata_o, 32'hDEAD_BEEF);
        chk("ld_err",    {31'b0, mem_err_o}, 32'h0);
        chk("ld_if_ack", {31'b0, if_ack_o}, 32'h0);
        chk("ld_stall",  {31'b0, stall_mem_o}, 32'h0);
        tick();
        bus.bus_ack_i = 1'b0; mem_req_i = 1'b0;
        @(negedge clk);
        chk("ld_req_drop", {31'b0, bus.bus_req_o}, 32'h0);
        chk("ld_ack_once", {31'b0, mem_ack_o}, 32'h0);
        chk("ld_rdata_0",  mem_rdata_o, 32'h0);

        // simultaneous IF fetch and MEM store: MEM first, IF after one IDLE cycle
        tick();
        if_req_i = 1'b1; if_addr_i = 32'h0;
        mem_req_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = 32'h200;
        mem_wdata_i = 32'h1234_5678; mem_sel_i = 4'h3;
        tick();
        bus.bus_ack_i = 1'b1; bus.bus_rdata_i = 32'hAAAA_5555;
        @(negedge clk);
        chk("sim_mem_we",    {31'b0, bus.bus_we_o}, 32'h1);
        chk("sim_mem_sel",   {28'b0, bus.bus_sel_o}, 32'h3);
        chk("sim_mem_addr",  bus.bus_addr_o, 32'h200);
        chk("sim_mem_wdata", bus.bus_wdata_o, 32'h1234_5678);
        chk("sim_mem_ack",   {31'b0, mem_ack_o}, 32'h1);
        chk("sim_if_ack",    {31'b0, if_ack_o}, 32'h0);
        chk("sim_if_rdata",  if_rdata_o, 32'h0);
        chk("sim_if_stall",  {31'b0, stall_if_o}, 32'h1);
        tick();
        bus.bus_ack_i = 1'b0; mem_req_i = 1'b0;
        @(negedge clk);
        chk("sim_gap_req", {31'b0, bus.bus_req_o}, 32'h0);
        tick();
        bus.bus_ack_i = 1'b1; bus.bus_rdata_i = 32'h0000_0013;
        @(negedge clk);
        chk("sim_if_req",   {31'b0, bus.bus_req_o}, 32'h1);
        chk("sim_if_sel",   {28'b0, bus.bus_sel_o}, 32'hF);
        chk("sim_if_we",    {31'b0, bus.bus_we_o}, 32'h0);
        chk("sim_if_wdata", bus.bus_wdata_o, 32'h0);
        chk("sim_if_ack2",  {31'b0, if_ack_o}, 32'h1);
        chk("sim_if_rd2",   if_rdata_o, 32'h0000_0013);
        chk("sim_mem_ack2", {31'b0, mem_ack_o}, 32'h0);
        tick();
        bus.bus_ack_i = 1'b0; if_req_i = 1'b0;

        // fetch with three wait states: stall held until the ack cycle
        tick();
        if_req_i = 1'b1; if_addr_i = 32'h40;
        @(negedge clk);
        chk("st_idle", {31'b0, stall_if_o}, 32'h1);
        for (int w = 0; w < 3; w++) begin
            tick();
            @(negedge clk);
            chk("st_wait", {31'b0, stall_if_o}, 32'h1);
        end
        tick();
        bus.bus_ack_i = 1'b1; bus.bus_rdata_i = 32'h0BAD_F00D;
        @(negedge clk);
        chk("st_ack",   {31'b0, if_ack_o}, 32'h1);
        chk("st_stall", {31'b0, stall_if_o}, 32'h0);
        chk("st_rdata", if_rdata_o, 32'h0BAD_F00D);
        tick();
        bus.bus_ack_i = 1'b0; if_req_i = 1'b0;

        // starvation: MEM always requesting, IF waiting -> grants M,M,M,M,IF
        tick();
        if_req_i = 1'b1; if_addr_i = 32'h80;
        mem_req_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = 32'h400;
        mem_wdata_i = 32'h0; mem_sel_i = 4'h3;
        for (int g = 0; g < 5; g++) begin
            tick();
            bus.bus_ack_i = 1'b1; bus.bus_rdata_i = 32'h0;
            @(negedge clk);
            chk("sv_sel",     {28'b0, bus.bus_sel_o}, (g < 4) ? 32'h3 : 32'hF);
            chk("sv_mem_ack", {31'b0, mem_ack_o},     (g < 4) ? 32'h1 : 32'h0);
            chk("sv_if_ack",  {31'b0, if_ack_o},      (g < 4) ? 32'h0 : 32'h1);
            tick();
            bus.bus_ack_i = 1'b0;
            if (g == 4) begin
                if_req_i = 1'b0; mem_req_i = 1'b0;
            end
        end

        // timeout: bus never acks, error completion in 16th strobe cycle
        tick();
        mem_req_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h300; mem_sel_i = 4'hF;
        bus.bus_rdata_i = 32'hFFFF_FFFF;
        tick();
        @(negedge clk);
        cyc = 1;
        while (mem_ack_o !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk("to_cycles", cyc, 32'd16);
        chk("to_err",    {31'b0, mem_err_o}, 32'h1);
        chk("to_rdata",  mem_rdata_o, 32'h0);
        chk("to_req_hi", {31'b0, bus.bus_req_o}, 32'h1);
        tick();
        mem_req_i = 1'b0;
        @(negedge clk);
        chk("to_req_lo", {31'b0, bus.bus_req_o}, 32'h0);
        chk("to_ack_lo", {31'b0, mem_ack_o}, 32'h0);

        // ack arriving in the expiry cycle is a normal completion
        tick();
        mem_req_i = 1'b1; mem_addr_i = 32'h304;
        tick();
        for (int k = 0; k < 15; k++) tick();
        bus.bus_ack_i = 1'b1; bus.bus_rdata_i = 32'hCAFE_F00D;
        @(negedge clk);
        chk("tx_ack",   {31'b0, mem_ack_o}, 32'h1);
        chk("tx_err",   {31'b0, mem_err_o}, 32'h0);
        chk("tx_rdata", mem_rdata_o, 32'hCAFE_F00D);
        tick();
        bus.bus_ack_i = 1'b0; mem_req_i = 1'b0;

        // reset while MEM owns the bus, then a late ack
        tick();
        mem_req_i = 1'b1; mem_addr_i = 32'h500;
        tick();
        @(negedge clk);
        chk("rb_req", {31'b0, bus.bus_req_o}, 32'h1);
        tick();
        rst = 1'b1; bus.bus_ack_i = 1'b1; bus.bus_rdata_i = 32'h7777_7777;
        @(negedge clk);
        chk("rb_ack_in_rst",   {31'b0, mem_ack_o}, 32'h0);
        chk("rb_rdata_in_rst", mem_rdata_o, 32'h0);
        chk("rb_stall_in_rst", {31'b0, stall_mem_o}, 32'h0);
        tick();
        rst = 1'b0; mem_req_i = 1'b0;
        @(negedge clk);
        chk("rb_late_ack", {31'b0, mem_ack_o}, 32'h0);
        chk("rb_req_lo",   {31'b0, bus.bus_req_o}, 32'h0);
        tick();
        bus.bus_ack_i = 1'b0;
        @(negedge clk);
        chk("rb_idle", {31'b0, bus.bus_req_o}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
